// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shared memory controller sitting below the CPU's two cache ports
//   (port 1 = icache, port 0 = dcache). Arbitrates between the ports and
//   serialises each 32-bit word access into four byte accesses on a
//   byte-wide synchronous RAM (read data valid the cycle after its address).
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous reset, active-low
//   mem_rw_flag_i  : per port [2p+1:2p], bit0 = read req, bit1 = write req
//   mem_addr_i     : per port [32p+31:32p], word byte address
//   mem_w_data_i   : per port write data, byte k at bits [8k+7:8k]
//   mem_w_mask_i   : per port [4p+3:4p], write byte enables
//   mem_r_data_o   : per port read data register
//   mem_busy_o     : per port, request pending or in service
//   mem_done_o     : per port, one-cycle completion pulse
//   ram_addr_o     : RAM byte address
//   ram_we_o       : RAM write enable
//   ram_w_data_o   : RAM write byte
//   ram_r_data_i   : RAM read byte
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            mem_rw_flag_i,
    input  logic [63:0]           mem_addr_i,
    input  logic [63:0]           mem_w_data_i,
    input  logic [7:0]            mem_w_mask_i,
    output logic [63:0]           mem_r_data_o,
    output logic [1:0]            mem_busy_o,
    output logic [1:0]            mem_done_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [7:0]            ram_w_data_o,
    input  logic [7:0]            ram_r_data_i
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            mask_q, mask_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  ram_we_q, ram_we_d;
    logic [7:0]            ram_wdata_q, ram_wdata_d;
    logic [63:0]           rdata_q, rdata_d;
    logic [1:0]            done_prev_q;

    logic [1:0]  elig;
    logic        gnt;
    logic [1:0]  req_flag;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_mask;
    logic [1:0]  nxt;
    logic [1:0]  rbyte;
    logic [5:0]  roff;
    logic [1:0]  done_vec;
    logic        active;
    logic        unused_addr_bits;

    // Upper request address bits are deliberately ignored.
    assign unused_addr_bits = ^{mem_addr_i[63:32+ADDR_WIDTH], mem_addr_i[31:ADDR_WIDTH]};

    // A port that completed last cycle sits out one arbitration round, which
    // both lets the requester drop its flag and makes held ties alternate.
    assign elig[0] = (|mem_rw_flag_i[1:0]) & ~done_prev_q[0];
    assign elig[1] = (|mem_rw_flag_i[3:2]) & ~done_prev_q[1];
    assign gnt     = (&elig) ? ~last_q : elig[1];

    assign req_flag  = gnt ? mem_rw_flag_i[3:2] : mem_rw_flag_i[1:0];
    assign req_addr  = gnt ? mem_addr_i[63:32]  : mem_addr_i[31:0];
    assign req_wdata = gnt ? mem_w_data_i[63:32] : mem_w_data_i[31:0];
    assign req_mask  = gnt ? mem_w_mask_i[7:4]  : mem_w_mask_i[3:0];

    // nxt is the byte index of the next address to drive; rbyte is the byte
    // whose RAM data arrives this cycle (cnt-1, with cnt=4 mapping to 3).
    assign nxt   = cnt_q[1:0] + 2'd1;
    assign rbyte = cnt_q[1:0] - 2'd1;
    assign roff  = {owner_q, rbyte, 3'b000};

    assign active   = (state_q == READ) || (state_q == WRITE);
    assign done_vec = (state_q == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = ram_we_q;
        ram_wdata_d = ram_wdata_q;
        rdata_d     = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    owner_d    = gnt;
                    addr_d     = req_addr[ADDR_WIDTH-1:0];
                    wdata_d    = req_wdata;
                    mask_d     = req_mask;
                    cnt_d      = 3'd0;
                    ram_addr_d = req_addr[ADDR_WIDTH-1:0];
                    if (req_flag[1]) begin
                        state_d     = WRITE;
                        ram_we_d    = req_mask[0];
                        ram_wdata_d = req_wdata[7:0];
                    end else begin
                        state_d  = READ;
                        ram_we_d = 1'b0;
                    end
                end
            end
            READ: begin
                if (cnt_q != 3'd0) begin
                    rdata_d[roff +: 8] = ram_r_data_i;
                end
                if (cnt_q == 3'd4) begin
                    state_d = DONE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < 3'd3) begin
                        ram_addr_d = addr_q + ADDR_WIDTH'(nxt);
                    end
                end
            end
            WRITE: begin
                if (cnt_q == 3'd3) begin
                    state_d  = DONE;
                    cnt_d    = 3'd0;
                    ram_we_d = 1'b0;
                end else begin
                    cnt_d       = cnt_q + 3'd1;
                    ram_addr_d  = addr_q + ADDR_WIDTH'(nxt);
                    ram_we_d    = mask_q[nxt];
                    ram_wdata_d = wdata_q[{nxt, 3'b000} +: 8];
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            rdata_q     <= '0;
            done_prev_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            rdata_q     <= rdata_d;
            done_prev_q <= done_vec;
        end
    end

    // A waiting port reports busy while the other port holds the RAM,
    // including during the other port's DONE cycle.
    assign mem_busy_o[0] = rst & ((active & ~owner_q) |
                                  ((|mem_rw_flag_i[1:0]) & (state_q != IDLE) & owner_q));
    assign mem_busy_o[1] = rst & ((active & owner_q) |
                                  ((|mem_rw_flag_i[3:2]) & (state_q != IDLE) & ~owner_q));

    assign mem_done_o   = done_vec;
    assign mem_r_data_o = rdata_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_we_o     = ram_we_q;
    assign ram_w_data_o = ram_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW    = 17;
    localparam int MSIZE = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    flag;
    logic [63:0]   addr_in;
    logic [63:0]   wdata_in;
    logic [7:0]    mask_in;
    logic [63:0]   rdata;
    logic [1:0]    busy;
    logic [1:0]    done;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    logic [7:0]    ram     [0:MSIZE-1];
    logic [7:0]    ref_mem [0:MSIZE-1];
    logic          ram_init = 1'b0;
    logic [63:0]   exp_r;

    int checks   = 0;
    int failures = 0;

    int          n_done;
    int          order [0:3];
    int          cyc   [0:3];
    int          fc;
    logic [1:0]  fd;
    int          nd;
    int          rp;
    logic [1:0]  rfl;
    logic [31:0] ra;
    logic [31:0] rd;
    logic [3:0]  rm;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rw_flag_i(flag),
        .mem_addr_i   (addr_in),
        .mem_w_data_i (wdata_in),
        .mem_w_mask_i (mask_in),
        .mem_r_data_o (rdata),
        .mem_busy_o   (busy),
        .mem_done_o   (done),
        .ram_addr_o   (ram_addr),
        .ram_we_o     (ram_we),
        .ram_w_data_o (ram_wdata),
        .ram_r_data_i (ram_rdata)
    );

    function automatic logic [7:0] init_byte(input int a);
        if (a >= 256 && a < 260) return 8'((a - 255) * 17);
        return 8'((a * 37) ^ (a >> 7));
    endfunction

    // Byte-wide synchronous RAM
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < MSIZE; i++) ram[i] <= init_byte(i);
            ram_init <= 1'b1;
        end else if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [AW-1:0] b);
        return {ref_mem[AW'(b + 3)], ref_mem[AW'(b + 2)], ref_mem[AW'(b + 1)], ref_mem[b]};
    endfunction

    // Issue one request on port p and check it end to end against the model.
    task automatic run_req(input int p, input logic [1:0] fl, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        logic [AW-1:0] base;
        logic [AW-1:0] at [1:15];
        logic          wt [1:15];
        logic [1:0]    bz [1:15];
        int            lat;
        base = a[AW-1:0];
        flag = 4'b0;
        flag[2*p +: 2]      = fl;
        addr_in[32*p +: 32] = a;
        wdata_in[32*p +: 32] = d;
        mask_in[4*p +: 4]   = m;
        lat = 0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            at[k] = ram_addr;
            wt[k] = ram_we;
            bz[k] = busy;
            if (done[p]) begin
                lat = k;
                break;
            end
        end
        flag = 4'b0;
        if (fl[1]) begin
            for (int k = 0; k < 4; k++)
                if (m[k]) ref_mem[AW'(base + AW'(k))] = d[8*k +: 8];
        end else begin
            exp_r[32*p +: 32] = ref_word(base);
        end
        chk("latency", 64'(lat), fl[1] ? 64'd5 : 64'd6);
        if (lat >= 5) begin
            chk("busy_first", 64'(bz[1][p]), 64'd1);
            chk("busy_last", 64'(bz[lat-1][p]), 64'd1);
            chk("busy_done", 64'(bz[lat][p]), 64'd0);
            for (int k = 1; k <= 4; k++) begin
                chk($sformatf("ram_addr_k%0d", k), 64'(at[k]), 64'(AW'(base + AW'(k - 1))));
                chk($sformatf("ram_we_k%0d", k), 64'(wt[k]), 64'(fl[1] & m[k-1]));
            end
        end
        repeat (2) begin @(posedge clk); #1; end
        chk("r_data", rdata, exp_r);
        if (fl[1]) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("ram_byte%0d", k), 64'(ram[AW'(base + AW'(k))]),
                    64'(ref_mem[AW'(base + AW'(k))]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < MSIZE; i++) ref_mem[i] = init_byte(i);
        exp_r    = 64'h0;
        rst      = 1'b0;
        flag     = 4'b1111;
        addr_in  = 64'h0;
        wdata_in = 64'h0;
        mask_in  = 8'h00;

        // Reset with both ports requesting
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_we", 64'(ram_we), 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        rst = 1'b1;
        fd = 2'b00;
        fc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (done != 2'b00) begin
                fd = done;
                fc = c;
                break;
            end
        end
        flag = 4'b0;
        chk("first_grant_port", 64'(fd), 64'd1);
        chk("first_grant_lat", 64'(fc), 64'd5);
        repeat (2) begin @(posedge clk); #1; end

        // Directed reads/writes
        run_req(0, 2'b01, 32'h0000_0100, 32'h0, 4'h0);
        run_req(0, 2'b10, 32'h0000_0200, 32'hAABB_CCDD, 4'b0101);
        run_req(0, 2'b11, 32'h0000_0204, 32'hAABB_CCDD, 4'b0101);
        run_req(1, 2'b01, 32'h0001_FFFE, 32'h0, 4'h0);
        run_req(1, 2'b11, 32'hFFFF_FFFF, 32'h1234_5678, 4'b1111);

        // Held tie: grants alternate 0,1,0,1
        flag    = 4'b0101;
        addr_in = {32'h0000_0300, 32'h0000_0100};
        n_done  = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (n_done == 0) chk($sformatf("tie_busy1_c%0d", c), 64'(busy[1]), 64'd1);
            if (done != 2'b00) begin
                order[n_done] = done[1] ? 1 : 0;
                cyc[n_done]   = c;
                n_done++;
                if (n_done == 4) break;
            end
        end
        flag = 4'b0;
        chk("tie_count", 64'(n_done), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tie_order%0d", i), 64'(order[i]), 64'(i % 2));
            chk($sformatf("tie_cycle%0d", i), 64'(cyc[i]), 64'(6 + 7 * i));
        end
        exp_r = {ref_word(AW'(32'h300)), ref_word(AW'(32'h100))};
        repeat (2) begin @(posedge clk); #1; end
        chk("tie_rdata", rdata, exp_r);

        // Reset in the middle of a write
        flag          = 4'b0010;
        addr_in[31:0] = 32'h0000_0400;
        wdata_in[31:0] = 32'h0102_0304;
        mask_in[3:0]  = 4'hF;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        nd  = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done != 2'b00) nd++;
        end
        rst  = 1'b1;
        flag = 4'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done != 2'b00) nd++;
        end
        ref_mem[AW'(32'h400)] = 8'h04;
        ref_mem[AW'(32'h401)] = 8'h03;
        exp_r = 64'h0;
        chk("abort_nodone", 64'(nd), 64'd0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("abort_byte%0d", k), 64'(ram[AW'(32'h400 + k)]),
                64'(ref_mem[AW'(32'h400 + k)]));
        chk("abort_rdata", rdata, exp_r);
        run_req(0, 2'b01, 32'h0000_0400, 32'h0, 4'h0);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            rp  = int'($urandom % 2);
            rfl = 2'($urandom_range(1, 3));
            ra  = $urandom;
            if ($urandom % 4 == 0) ra[AW-1:0] = 17'h1FFFC | 17'($urandom % 4);
            rd  = $urandom;
            rm  = 4'($urandom);
            run_req(rp, rfl, ra, rd, rm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
